// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Serial boot loader. Parses A5-framed byte streams from a UART
//               receiver and writes the payload into a 16K x 8 ROM, with
//               length, checksum and inter-byte timeout checking.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader #(
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic        busy,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [15:0] LEN_MAX  = 16'd16384;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR_L = 3'd1;
  localparam logic [2:0] S_ADDR_H = 3'd2;
  localparam logic [2:0] S_LEN_L  = 3'd3;
  localparam logic [2:0] S_LEN_H  = 3'd4;
  localparam logic [2:0] S_DATA   = 3'd5;
  localparam logic [2:0] S_CSUM   = 3'd6;

  logic [2:0]       state;
  logic [2:0]       next_state;

  // synchronizer chain and edge detect
  logic             sync1;
  logic             sync2;
  logic             sync_hist;
  logic             valid1;
  logic             valid2;
  logic             armed;
  logic             accept;

  // frame bookkeeping
  logic [13:0]      addr_ptr;
  logic [7:0]       len_lo;
  logic [15:0]      len_full;
  logic [14:0]      remaining;
  logic [7:0]       csum;
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_hit;

  // next-cycle values of the registered outputs
  logic             wr_en_nxt;
  logic             done_nxt;
  logic             error_nxt;
  logic [1:0]       err_code_nxt;

  // Synchronize rx_ready; the valid pipe marks when sync2 reflects the real
  // input rather than its reset value, so a level already high at reset
  // release must first be seen low before a rising edge can be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_hist <= 1'b0;
      valid1    <= 1'b0;
      valid2    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sync1     <= rx_ready;
      sync2     <= sync1;
      sync_hist <= sync2;
      valid1    <= 1'b1;
      valid2    <= valid1;
      if (valid2 && !sync2) begin
        armed <= 1'b1;
      end
    end
  end

  assign accept   = armed & sync2 & ~sync_hist;
  assign len_full = {rx_byte, len_lo};

  // Inter-byte timeout counter: idle and every accepted byte restart it.
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE || accept) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // An acceptance on the expiry cycle takes precedence over the timeout.
  assign timeout_hit = (state != S_IDLE) && !accept &&
                       (to_cnt == CNT_W'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic: one header field per accepted byte.
  always_comb begin
    next_state = state;
    if (accept) begin
      case (state)
        S_IDLE:   if (rx_byte == SYNC_BYTE) next_state = S_ADDR_L;
        S_ADDR_L: next_state = S_ADDR_H;
        S_ADDR_H: next_state = S_LEN_L;
        S_LEN_L:  next_state = S_LEN_H;
        S_LEN_H: begin
          if (len_full > LEN_MAX) begin
            next_state = S_IDLE;
          end else if (len_full == 16'd0) begin
            next_state = S_CSUM;
          end else begin
            next_state = S_DATA;
          end
        end
        S_DATA:   if (remaining == 15'd1) next_state = S_CSUM;
        S_CSUM:   next_state = S_IDLE;
        default:  next_state = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      next_state = S_IDLE;
    end
  end

  // FSM output decode: write strobe and completion/error pulses.
  always_comb begin
    wr_en_nxt    = 1'b0;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;
    err_code_nxt = err_code;
    if (accept) begin
      case (state)
        S_LEN_H: begin
          if (len_full > LEN_MAX) begin
            error_nxt    = 1'b1;
            err_code_nxt = 2'b01;
          end
        end
        S_DATA:  wr_en_nxt = 1'b1;
        S_CSUM: begin
          if (rx_byte == csum) begin
            done_nxt = 1'b1;
          end else begin
            error_nxt    = 1'b1;
            err_code_nxt = 2'b10;
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      error_nxt    = 1'b1;
      err_code_nxt = 2'b11;
    end
  end

  // Registered outputs; busy falls in the same cycle as the done/error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'b00;
    end else begin
      busy     <= (next_state != S_IDLE);
      wr_en    <= wr_en_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
      err_code <= err_code_nxt;
    end
  end

  // Frame datapath: header capture, write address/data, running checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_ptr  <= '0;
      len_lo    <= '0;
      remaining <= '0;
      csum      <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (accept) begin
      case (state)
        S_IDLE:   if (rx_byte == SYNC_BYTE) csum <= '0;
        S_ADDR_L: addr_ptr[7:0]  <= rx_byte;
        S_ADDR_H: addr_ptr[13:8] <= rx_byte[5:0];
        S_LEN_L:  len_lo <= rx_byte;
        S_LEN_H:  remaining <= len_full[14:0];
        S_DATA: begin
          wr_addr   <= addr_ptr;
          wr_data   <= rx_byte;
          addr_ptr  <= addr_ptr + 14'd1;
          remaining <= remaining - 15'd1;
          csum      <= csum + rx_byte;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter TIMEOUT, default 1000000, inter-byte timeout in clk cycles (10 ms at 100 MHz).
REQ-002 clk  input  1  system clock, 100 MHz; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_byte  input  8  received UART byte; stable while rx_ready is high.
REQ-005 rx_ready  input  1  byte-valid level from the serial receiver, asynchronous to clk (12 MHz domain).
REQ-006 busy  output  1  load in progress; drives CPU reset and ROM write-port select.
REQ-007 wr_en  output  1  single-cycle ROM write strobe.
REQ-008 wr_addr  output  14  ROM write address.
REQ-009 wr_data  output  8  ROM write data.
REQ-010 done  output  1  single-cycle pulse on a successful load.
REQ-011 error  output  1  single-cycle pulse on an aborted or failed load.
REQ-012 err_code  output  2  cause of the last error: 01 bad length, 10 checksum, 11 timeout; holds until the next error or reset.

Function
REQ-013 Input sync: rx_ready passes through a 2-flop synchronizer plus a history flop.
- A byte is accepted on the rising edge of the synchronized signal.
- Acceptance occurs at the 3rd clk edge at which rx_ready is sampled high; rx_byte is captured at that edge.
REQ-014 Frame format, little-endian:
- 0xA5 sync byte
- ADDR_L, ADDR_H (start address; only 14 LSBs used)
- LEN_L, LEN_H (byte count)
- LEN data bytes
- CSUM
REQ-015 FSM states: IDLE, ADDR_L, ADDR_H, LEN_L, LEN_H, DATA, CSUM; each accepted byte advances exactly one header state.
REQ-016 IDLE: bytes other than 0xA5 are ignored with no output activity; 0xA5 moves to ADDR_L and sets busy in the next cycle.
REQ-017 LEN_H check: the 16-bit LEN is range-checked when LEN_H is accepted.
- LEN > 16384: error pulse, err_code=01, return to IDLE.
- LEN = 0: go directly to CSUM.
- Otherwise: go to DATA.
REQ-018 DATA, per accepted byte:
- wr_data=byte, wr_addr=(start+index) mod 16384, wr_en high for exactly the cycle after acceptance.
- Index runs 0..LEN-1; the address wraps 3FFF->0000.
REQ-019 Checksum: running 8-bit sum, mod 256, of data bytes only; cleared on entry to ADDR_L.
REQ-020 CSUM: accepted byte equal to the sum -> done pulse; otherwise error pulse with err_code=10.
- Either way, return to IDLE and deassert busy in the cycle of the pulse.
- Already-written bytes are not undone.
REQ-021 Timeout counter: cleared on every accepted byte and held at zero in IDLE.
- In any non-IDLE state, reaching TIMEOUT cycles without an accepted byte -> error pulse, err_code=11, return to IDLE.
REQ-022 Byte acceptance and timeout expiry in the same cycle: acceptance wins and the counter clears.
REQ-023 wr_en, done and error are mutually exclusive and never high for more than one consecutive cycle.
REQ-024 wr_addr/wr_data hold their last values when wr_en is low.
REQ-025 busy is high from the cycle after sync acceptance until the cycle of the done or error pulse, inclusive of the pulse cycle's deassertion.

Reset
REQ-026 On reset, all outputs are driven to 0, including err_code=00 and wr_addr=0000.
- FSM returns to IDLE; checksum, index and timeout counters clear; synchronizer flops clear.
REQ-027 Reset mid-frame aborts silently: no wr_en, done or error pulse; a subsequent frame must begin with 0xA5.
REQ-028 A rx_ready already high when reset releases is not accepted until it goes low and high again.

Verification
REQ-029 Frame A5 00 10 03 00 11 22 33 66 -> writes 1000=11, 1001=22, 1002=33, one wr_en pulse each; done pulse; busy low afterwards.
REQ-030 Frame A5 FE 3F 04 00 01 02 03 04 0A -> writes at 3FFE, 3FFF, 0000, 0001; done pulse.
REQ-031 Frame A5 00 00 02 00 AA 55 00 -> two writes, then error pulse with err_code=10.
REQ-032 Header A5 00 00 01 40 -> error, err_code=01, no wr_en; header A5 00 00 00 40 then CSUM 00 -> 16384 writes expected (length boundary).
REQ-033 A5 00 00 then silence for TIMEOUT cycles -> error, err_code=11 at cycle TIMEOUT after the last acceptance; a byte arriving on the expiry cycle is accepted and no error is raised.
REQ-034 Junk 00 FF 5A in IDLE -> no activity; reset asserted during DATA -> busy=0 next cycle, with no pulses.
